// File: rtl/instr_cycle_sequencer.sv
// instr_cycle_sequencer: fetch/execute sequencer feeding the instruction
// decoder's ir and cycle inputs. It fetches opcode bytes over a req/ack
// handshake, steps cycle through each opcode's execution length, and halts
// on HALT_OP or on an illegal opcode.
// Optional feature: define SEQ_SINGLE_STEP_EN to add the step input. Each
// EXEC advance then waits for step=1.
module instr_cycle_sequencer #(
   parameter int              PC_W    = 8,
   parameter logic [7:0]      HALT_OP = 8'h0F
) (
   input  logic               sys_clock,
   input  logic               rst,
   input  logic               run,
   output logic               mem_req,
   output logic [PC_W-1:0]    mem_addr,
   input  logic               mem_ack,
   input  logic [7:0]         mem_rdata,
   output logic [7:0]         ir,
   output logic [2:0]         cycle,
   output logic               ex_valid,
   output logic [PC_W-1:0]    pc,
   output logic               halted,
   output logic               illegal
`ifdef SEQ_SINGLE_STEP_EN
   ,
   input  logic               step
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_e;

   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [7:0]        ir_q, ir_d;
   logic [2:0]        cycle_q, cycle_d;
   logic              halted_q, halted_d;
   logic              illegal_q, illegal_d;
   logic              advance;

   // Index of the last execution cycle for a legal opcode (length minus one).
   function automatic logic [2:0] last_cycle(input logic [7:0] op);
      return (op == 8'h01) ? 3'd1 : 3'd0;
   endfunction

   // Opcodes that run through EXEC. HALT_OP is tested before this, so it
   // takes priority if it is ever overridden to one of these values.
   function automatic logic is_exec_op(input logic [7:0] op);
      return (op == 8'h00) || (op == 8'h01) || (op == 8'h02) || (op == 8'h03);
   endfunction

`ifdef SEQ_SINGLE_STEP_EN
   assign advance = step;
`else
   assign advance = 1'b1;
`endif

   // State and datapath registers; an asynchronous reset clears everything.
   always_ff @(posedge sys_clock or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         ir_q      <= '0;
         cycle_q   <= '0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         cycle_q   <= cycle_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
      end
   end

   // Next-state and datapath update logic.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      cycle_d   = cycle_q;
      halted_d  = halted_q;
      illegal_d = illegal_q;
      unique case (state_q)
         IDLE: begin
            if (run) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (mem_ack) begin
               ir_d    = mem_rdata;
               pc_d    = pc_q + PC_ONE;
               cycle_d = '0;
               if (mem_rdata == HALT_OP) begin
                  state_d  = HALT;
                  halted_d = 1'b1;
               end else if (is_exec_op(mem_rdata)) begin
                  state_d = EXEC;
               end else begin
                  state_d   = HALT;
                  halted_d  = 1'b1;
                  illegal_d = 1'b1;
               end
            end
         end
         EXEC: begin
            if (advance) begin
               if (cycle_q == last_cycle(ir_q)) begin
                  cycle_d = '0;
                  state_d = run ? FETCH : IDLE;
               end else begin
                  cycle_d = cycle_q + 3'd1;
               end
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The handshake and valid outputs decode directly from the state register.
   always_comb begin
      mem_req  = 1'b0;
      ex_valid = 1'b0;
      if (state_q == FETCH) begin
         mem_req = 1'b1;
      end
      if (state_q == EXEC) begin
         ex_valid = 1'b1;
      end
   end

   assign mem_addr = pc_q;
   assign pc       = pc_q;
   assign ir       = ir_q;
   assign cycle    = cycle_q;
   assign halted   = halted_q;
   assign illegal  = illegal_q;

endmodule

// File: tb/tb_instr_cycle_sequencer.sv
// Testbench for instr_cycle_sequencer. A reference model expands each
// program into the expected executed (ir, cycle) stream, the fetch
// addresses and the final flags. A monitor pops and compares on every
// ex_valid / accepted fetch.
module tb_instr_cycle_sequencer;

   localparam int         PC_W    = 8;
   localparam logic [7:0] HALT_OP = 8'h0F;

   logic              sys_clock = 1'b0;
   logic              rst;
   logic              run;
   logic              mem_req;
   logic [PC_W-1:0]   mem_addr;
   logic              mem_ack;
   logic [7:0]        mem_rdata;
   logic [7:0]        ir;
   logic [2:0]        cycle;
   logic              ex_valid;
   logic [PC_W-1:0]   pc;
   logic              halted;
   logic              illegal;
`ifdef SEQ_SINGLE_STEP_EN
   logic              step;
`endif

   instr_cycle_sequencer #(.PC_W(PC_W), .HALT_OP(HALT_OP)) dut (
      .sys_clock (sys_clock),
      .rst       (rst),
      .run       (run),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .ir        (ir),
      .cycle     (cycle),
      .ex_valid  (ex_valid),
      .pc        (pc),
      .halted    (halted),
      .illegal   (illegal)
`ifdef SEQ_SINGLE_STEP_EN
      ,
      .step      (step)
`endif
   );

   always #5 sys_clock = ~sys_clock;

   typedef struct packed {
      logic [7:0] op;
      logic [2:0] cyc;
   } ex_t;

   int              checks   = 0;
   int              failures = 0;
   logic [7:0]      prog[$];
   int              waits[$];
   ex_t             exp_ex[$];
   logic [PC_W-1:0] exp_addr[$];
   logic            exp_halted, exp_illegal;
   logic [PC_W-1:0] exp_pc;
   logic [7:0]      exp_ir;
   bit              sb_en      = 0;
   bit              run_random = 0;
   bit              will_accept = 0;
   int              fetch_idx  = 0;
   int              wait_cnt   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s: event occurred, none expected, at %0t", name, $time);
   endtask

   // Reference model: walk the fetch stream and expand each opcode.
   function automatic void build_model();
      exp_ex.delete();
      exp_addr.delete();
      exp_halted  = 1'b0;
      exp_illegal = 1'b0;
      exp_pc      = '0;
      exp_ir      = '0;
      for (int i = 0; i < prog.size(); i++) begin
         logic [7:0] op;
         int len;
         op = prog[i];
         len = 0;
         exp_addr.push_back(PC_W'(i % (1 << PC_W)));
         exp_ir = op;
         exp_pc = PC_W'((i + 1) % (1 << PC_W));
         if (op == HALT_OP) begin
            exp_halted = 1'b1;
            break;
         end else if (op == 8'h01) begin
            len = 2;
         end else if (op == 8'h00 || op == 8'h02 || op == 8'h03) begin
            len = 1;
         end else begin
            exp_halted  = 1'b1;
            exp_illegal = 1'b1;
            break;
         end
         for (int c = 0; c < len; c++) begin
            exp_ex.push_back('{op: op, cyc: 3'(c)});
         end
      end
   endfunction

   task automatic gen_random(input int n, input bit bad_end);
      logic [7:0] b;
      prog.delete();
      waits.delete();
      for (int i = 0; i < n; i++) begin
         prog.push_back(8'($urandom_range(3)));
         waits.push_back(int'($urandom_range(3)));
      end
      if (bad_end) begin
         do b = 8'($urandom); while (b <= 8'h03 || b == HALT_OP);
      end else begin
         b = HALT_OP;
      end
      prog.push_back(b);
      waits.push_back(int'($urandom_range(3)));
   endtask

   // Memory responder and random run driver, acting 1 ns after each edge.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge sys_clock);
         #1;
         if (rst) begin
            if (will_accept) begin
               fetch_idx++;
               wait_cnt = 0;
            end
            if (run_random) run = ($urandom_range(3) != 0);
         end
         if (mem_req && fetch_idx < prog.size()) begin
            if (wait_cnt >= waits[fetch_idx]) begin
               mem_ack   = 1'b1;
               mem_rdata = prog[fetch_idx];
            end else begin
               mem_ack   = 1'b0;
               mem_rdata = 8'($urandom);
               wait_cnt++;
            end
         end else begin
            mem_ack   = 1'($urandom_range(1));
            mem_rdata = 8'($urandom);
         end
      end
   end

   // Monitor: compare DUT activity against the model queues on falling edges.
   initial begin
      logic            prev_req, prev_ack, prev_run;
      logic [PC_W-1:0] prev_addr;
      logic [7:0]      prev_ir;
      ex_t             e;
      logic [PC_W-1:0] a;
      prev_req = 0; prev_ack = 0; prev_run = 0; prev_addr = '0; prev_ir = '0;
      forever begin
         @(negedge sys_clock);
         if (!rst) begin
            prev_req = 0; prev_ack = 0; prev_run = 0;
            will_accept = 0;
            continue;
         end
         will_accept = mem_req && mem_ack;
         if (sb_en) begin
            if (ex_valid) begin
               if (exp_ex.size() == 0) begin
                  fail("ex_valid_unexpected");
               end else begin
                  e = exp_ex.pop_front();
                  check("ex_ir", ir, e.op);
                  check("ex_cycle", cycle, e.cyc);
               end
            end
            if (mem_req && mem_ack) begin
               if (exp_addr.size() == 0) begin
                  fail("fetch_unexpected");
               end else begin
                  a = exp_addr.pop_front();
                  check("fetch_addr", mem_addr, a);
               end
            end
            if (mem_req && ex_valid) fail("req_and_ex_valid");
            if (prev_req && !prev_ack) begin
               check("req_held", mem_req, 1);
               check("addr_held", mem_addr, prev_addr);
               check("ir_held_during_wait", ir, prev_ir);
            end
            if (mem_req && !prev_req) check("req_rise_needs_run", prev_run, 1);
            if (halted) begin
               check("halt_no_req", mem_req, 0);
               check("halt_no_ex_valid", ex_valid, 0);
            end
         end
         prev_req  = mem_req;
         prev_ack  = mem_ack;
         prev_run  = run;
         prev_addr = mem_addr;
         prev_ir   = ir;
      end
   end

   task automatic start_prog(input bit rr);
      rst        = 1'b0;
      run        = 1'b0;
      sb_en      = 0;
      run_random = 0;
      build_model();
      fetch_idx  = 0;
      wait_cnt   = 0;
      @(posedge sys_clock);
      #1;
      check("reset_flags", {mem_req, ex_valid, halted, illegal}, 4'b0000);
      check("reset_ir", ir, 0);
      check("reset_cycle", cycle, 0);
      check("reset_pc", pc, 0);
      @(posedge sys_clock);
      #1;
      rst        = 1'b1;
      run        = 1'b1;
      run_random = rr;
      sb_en      = 1;
   endtask

   task automatic finish_prog(output int cyc);
      bit started, done;
      started = 0;
      done    = 0;
      cyc     = 0;
      for (int k = 0; k < 4000 && !done; k++) begin
         @(negedge sys_clock);
         if (mem_req) started = 1;
         if (started) cyc++;
         if (halted) done = 1;
      end
      if (!done) fail("halt_timeout");
      repeat (4) @(negedge sys_clock);
      check("final_halted", halted, exp_halted);
      check("final_illegal", illegal, exp_illegal);
      check("final_pc", pc, exp_pc);
      check("final_ir", ir, exp_ir);
      check("ex_stream_left", exp_ex.size(), 0);
      check("fetch_addr_left", exp_addr.size(), 0);
      sb_en      = 0;
      run_random = 0;
   endtask

   task automatic wait_posedge_until_ex(input string name);
      bit found;
      found = 0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(posedge sys_clock);
         #1;
         if (ex_valid) found = 1;
      end
      if (!found) fail(name);
   endtask

   initial begin
      int cyc;
      bit found;
      rst = 1'b0;
      run = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
      step = 1'b1;
`endif

      // Zero-wait program with the decoder-visible sequence and total length.
      prog  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h0F};
      waits = '{0, 0, 0, 0, 0};
      start_prog(0);
      finish_prog(cyc);
      check("zero_wait_clocks", cyc, 11);

      // Three wait states on the fetch of 8'h01.
      waits = '{0, 3, 0, 0, 0};
      start_prog(0);
      finish_prog(cyc);
      check("wait_state_clocks", cyc, 14);

      // Illegal opcode at pc 0.
      prog  = '{8'hFF};
      waits = '{0};
      start_prog(0);
      finish_prog(cyc);

      // Drop run during cycle 0 of 8'h01.
      prog  = '{8'h01, 8'h00, 8'h0F};
      waits = '{0, 0, 0};
      start_prog(0);
      wait_posedge_until_ex("run_drop_no_exec");
      check("run_drop_ir", ir, 8'h01);
      check("run_drop_cycle0", cycle, 0);
      run = 1'b0;
      @(posedge sys_clock); #1;
      check("run_drop_ex_valid", ex_valid, 1);
      check("run_drop_cycle1", cycle, 1);
      @(posedge sys_clock); #1;
      check("run_drop_idle", {mem_req, ex_valid}, 2'b00);
      repeat (2) begin
         @(posedge sys_clock); #1;
         check("run_drop_idle_req", mem_req, 0);
      end
      run = 1'b1;
      finish_prog(cyc);

      // PC wraps from 8'hFF to 0.
      gen_random(256, 0);
      prog[255] = 8'h00;
      foreach (waits[i]) waits[i] = 0;
      start_prog(0);
      finish_prog(cyc);

      // Asynchronous reset while a fetch is waiting for its ack.
      prog  = '{8'h00, 8'h01, 8'h0F};
      waits = '{0, 50, 0};
      start_prog(0);
      found = 0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(posedge sys_clock); #1;
         if (mem_req && fetch_idx == 1) found = 1;
      end
      if (!found) fail("mid_fetch_not_reached");
      repeat (2) @(posedge sys_clock);
      #2;
      rst = 1'b0;
      #1;
      check("midfetch_rst_flags", {mem_req, ex_valid, halted, illegal}, 4'b0000);
      check("midfetch_rst_ir", ir, 0);
      check("midfetch_rst_pc", pc, 0);
      check("midfetch_rst_cycle", cycle, 0);
      sb_en = 0;

      // Randomized programs, wait states and run toggling.
      for (int t = 0; t < 8; t++) begin
         gen_random(int'($urandom_range(1, 40)), bit'($urandom_range(1)));
         start_prog(1);
         finish_prog(cyc);
      end

`ifdef SEQ_SINGLE_STEP_EN
      // Single-step: EXEC holds until step pulses.
      prog  = '{8'h01, 8'h0F};
      waits = '{0, 0};
      step  = 1'b0;
      start_prog(0);
      sb_en = 0;
      wait_posedge_until_ex("step_no_exec");
      repeat (3) begin
         check("step_hold_cycle", cycle, 0);
         check("step_hold_ex_valid", ex_valid, 1);
         @(posedge sys_clock); #1;
      end
      step = 1'b1;
      @(posedge sys_clock); #1;
      step = 1'b0;
      check("step_cycle1", cycle, 1);
      check("step_cycle1_valid", ex_valid, 1);
      @(posedge sys_clock); #1;
      check("step_cycle1_hold", cycle, 1);
      step = 1'b1;
      @(posedge sys_clock); #1;
      step = 1'b0;
      check("step_to_fetch", {mem_req, ex_valid}, 2'b10);
      step = 1'b1;
      rst  = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/instr_cycle_sequencer.md
# instr_cycle_sequencer

- Fetch/execute sequencer that drives the instruction decoder's `ir` and `cycle` inputs.
- Fetches opcode bytes from program memory over a req/ack handshake and latches them into `ir`.
- Steps `cycle` through the opcode's execution length.
- Halts on the HALT opcode or an illegal opcode.
- Sits between program memory and `instructiondecoder`; the decoder's control signals are meaningful only while `ex_valid`=1.

## Interface
Parameters:
- PC_W, 8, program counter / memory address width
- HALT_OP, 8'h0F, opcode that stops the sequencer

Ports:
- sys_clock  in  1  system clock, rising-edge
- rst  in  1  reset, asynchronous, active-low
- run  in  1  level; 1 = keep fetching instructions
- mem_req  out  1  fetch request to program memory
- mem_addr  out  PC_W  fetch address (equals pc)
- mem_ack  in  1  memory has data on mem_rdata this cycle
- mem_rdata  in  8  fetched opcode byte
- ir  out  8  instruction register to decoder
- cycle  out  3  execution cycle index to decoder
- ex_valid  out  1  ir/cycle valid for execution this clock
- pc  out  PC_W  program counter
- halted  out  1  sticky halt flag
- illegal  out  1  sticky illegal-opcode flag
- step  in  1  single-step pulse (present only with SEQ_SINGLE_STEP_EN)

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- Reset (async, rst=0) sets every output to 0: state=IDLE, pc=0, ir=0, cycle=0, mem_req=0, ex_valid=0, halted=0, illegal=0.
- IDLE
  - run=1 → FETCH.
  - Otherwise stay; all handshake outputs are 0.
- FETCH
  - mem_req=1 and mem_addr=pc, held stable until mem_ack.
  - mem_ack is sampled on the rising edge; run is ignored while a request is open.
  - On ack:
    - ir←mem_rdata.
    - pc←pc+1, wrapping 2^PC_W−1→0.
    - mem_req deasserts next cycle.
    - Next state is chosen by opcode.
- Opcode lengths:
  - 8'h00, 8'h02, 8'h03: len=1.
  - 8'h01: len=2.
  - HALT_OP: no EXEC; → HALT with halted=1.
  - Any other value: → HALT with halted=1 and illegal=1. ir keeps the bad opcode.
- EXEC
  - ex_valid=1; cycle starts at 0 and increments each clock.
  - At cycle=len−1 the next state is FETCH if run=1, else IDLE. cycle returns to 0.
  - Dropping run mid-instruction always completes the instruction.
- HALT
  - ex_valid=0, mem_req=0.
  - Exit only via reset.
- cycle width is 3 bits; max len is 2, so cycle never exceeds 1.

## Timing
- Edge timing:
  - FETCH is entered on the edge after run=1 is seen in IDLE; mem_req is high that cycle.
  - With mem_ack=1 in the first FETCH cycle, ir/pc update on that edge and EXEC begins the next cycle.
- Best-case throughput with continuous run and zero-wait memory:
  - 1 fetch cycle + len exec cycles.
  - 2 clocks for len=1 opcodes; 3 clocks for 8'h01.
- Wait states: each cycle with mem_ack=0 in FETCH adds one clock. mem_rdata is ignored when mem_ack=0.
- ex_valid, ir and cycle are registered: they change only on rising edges and are stable for a full clock. The decoder samples them on its phase-2 clock.
- rst assertion in any state (including mid-FETCH with mem_req=1) returns to reset values immediately. No ack is consumed after reset.
- mem_ack outside FETCH is ignored.

## Configuration
- Macro: SEQ_SINGLE_STEP_EN.
- Defined:
  - The `step` port exists.
  - Each EXEC cycle advance (cycle increment, or leaving EXEC) requires step=1 on that edge; EXEC otherwise holds with ex_valid=1.
  - FETCH→EXEC is unaffected.
- Undefined:
  - No `step` port; EXEC advances every clock.

## Test plan
- Reset and start: rst low 15 ns, then high; run=1, memory {00,01,02,03,0F} at addresses 0-4 with zero-wait ack.
  - Required ir/cycle sequence: 00/0, 01/0, 01/1, 02/0, 03/0.
  - Then halted=1, illegal=0, pc=5, total 11 clocks from first mem_req.
- Wait states: ack delayed 3 clocks on fetch of 8'h01.
  - mem_req and mem_addr=1 are held stable for 4 clocks; ex_valid=0 throughout; ir updates only on the ack edge.
- Illegal opcode: mem_rdata=8'hFF at pc=0.
  - halted=1, illegal=1, ir=8'hFF, pc=1, ex_valid never asserts, mem_req stays 0 afterwards.
- run drop: deassert run during cycle 0 of 8'h01.
  - cycle 1 still executes, then IDLE with mem_req=0.
  - Reasserting run refetches from the next pc.
- Wrap and reset mid-fetch:
  - Wrap: pc=8'hFF fetching 8'h00 gives pc=0.
  - Reset mid-fetch: rst=0 while mem_req=1 clears all outputs within the same clock.
- Single step (SEQ_SINGLE_STEP_EN defined): opcode 8'h01 with step held low.
  - cycle stays 0 with ex_valid=1.
  - One step pulse gives cycle=1; a second pulse enters FETCH.
